// File: rtl/fifo_ctrl_sclk.sv
// Pointer/flag controller for a single-clock dual-port RAM FIFO.
// Never asserts the write and read strobes together: a write always takes priority.
module fifo_ctrl_sclk #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [CNT_WIDTH-1:0]  umbral_af,
  input  logic [CNT_WIDTH-1:0]  umbral_ae,
  output logic                  we_a,
  output logic                  re_a,
  output logic [ADDR_WIDTH-1:0] addr_wa,
  output logic [ADDR_WIDTH-1:0] addr_ra,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_ok, pop_ok;
  logic                  we, re;

  always_comb begin
    push_ok = push & ~full_q;
    pop_ok  = pop & ~empty_q;
    we      = ~reset & push_ok;
    // A granted pop yields to a granted push; the requester keeps pop asserted.
    re      = ~reset & pop_ok & ~push_ok;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (we) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      count_d  = count_q + CNT_WIDTH'(1);
    end else if (re) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      count_d  = count_q - CNT_WIDTH'(1);
    end

    rd_valid_d = re;
    full_d     = (count_d == CNT_WIDTH'(DEPTH));
    empty_d    = (count_d == '0);
    af_d       = (count_d >= umbral_af);
    ae_d       = (count_d <= umbral_ae);
    ovf_d      = ovf_q | (push & full_q);
    unf_d      = unf_q | (pop & empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign we_a          = we;
  assign re_a          = re;
  assign addr_wa       = wr_ptr_q;
  assign addr_ra       = rd_ptr_q;
  assign rd_valid      = rd_valid_q;
  assign fifo_count    = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign almost_full   = af_q;
  assign almost_empty  = ae_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_fifo_ctrl_sclk.sv
// Bench for fifo_ctrl_sclk: vector table plus hand sequences, with an 8x8 RAM model
// and a data scoreboard checking read order against granted writes.
module tb_fifo_ctrl_sclk;

  logic       clk = 1'b0;
  logic       reset, push, pop;
  logic [3:0] umbral_af, umbral_ae;
  logic       we_a, re_a, rd_valid;
  logic [2:0] addr_wa, addr_ra;
  logic [3:0] fifo_count;
  logic       full, empty, almost_full, almost_empty, overflow_err, underflow_err;
  logic [7:0] data_a, q_a;
  logic [7:0] mem [8];
  logic [7:0] sb [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  fifo_ctrl_sclk #(.ADDR_WIDTH(3), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .umbral_af(umbral_af), .umbral_ae(umbral_ae),
    .we_a(we_a), .re_a(re_a), .addr_wa(addr_wa), .addr_ra(addr_ra),
    .rd_valid(rd_valid), .fifo_count(fifo_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always @(posedge clk) begin
    if (we_a) mem[addr_wa] <= data_a;
    if (re_a) q_a <= mem[addr_ra];
  end

  typedef struct {
    logic       push, pop;
    logic       we, re;
    logic [2:0] wa, ra;
    logic [3:0] cnt;
    logic       fl, em, afl, ael, ovf, unf, rv;
  } vec_t;

  function automatic vec_t mk(input int p, q, we, re, wa, ra, cnt,
                              fl, em, afl, ael, ovf, unf, rv);
    vec_t v;
    v.push = 1'(p);   v.pop = 1'(q);
    v.we   = 1'(we);  v.re  = 1'(re);
    v.wa   = 3'(wa);  v.ra  = 3'(ra);
    v.cnt  = 4'(cnt);
    v.fl   = 1'(fl);  v.em  = 1'(em);
    v.afl  = 1'(afl); v.ael = 1'(ael);
    v.ovf  = 1'(ovf); v.unf = 1'(unf);
    v.rv   = 1'(rv);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    push   = v.push;
    pop    = v.pop;
    data_a = 8'($urandom);
    #1;
    chk("we_a", we_a, v.we);
    chk("re_a", re_a, v.re);
    chk("addr_wa", addr_wa, v.wa);
    chk("addr_ra", addr_ra, v.ra);
    if (v.we) sb.push_back(data_a);
    @(posedge clk);
    #1;
    chk("fifo_count", fifo_count, v.cnt);
    chk("full", full, v.fl);
    chk("empty", empty, v.em);
    chk("almost_full", almost_full, v.afl);
    chk("almost_empty", almost_empty, v.ael);
    chk("overflow_err", overflow_err, v.ovf);
    chk("underflow_err", underflow_err, v.unf);
    chk("rd_valid", rd_valid, v.rv);
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL q_a: rd_valid high with no data outstanding (t=%0t)", $time);
      end else begin
        chk("q_a", q_a, sb.pop_front());
      end
    end
  endtask

  task automatic do_reset(input logic p, input logic q);
    @(negedge clk);
    reset = 1'b1;
    push  = p;
    pop   = q;
    #1;
    chk("rst we_a", we_a, 0);
    chk("rst re_a", re_a, 0);
    @(posedge clk);
    #1;
    chk("rst addr_wa", addr_wa, 0);
    chk("rst addr_ra", addr_ra, 0);
    chk("rst fifo_count", fifo_count, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst full", full, 0);
    chk("rst empty", empty, 1);
    chk("rst almost_full", almost_full, 0);
    chk("rst almost_empty", almost_empty, 1);
    chk("rst overflow_err", overflow_err, 0);
    chk("rst underflow_err", underflow_err, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [$];
    int   wr, rd;

    reset = 1'b1; push = 1'b0; pop = 1'b0; data_a = '0;
    umbral_af = 4'd6; umbral_ae = 4'd2;

    // Fill, overflow, drain, underflow, push&pop on empty (thresholds 6/2)
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 0, 1, 0, i, 0, i + 1, i == 7, 0, (i + 1) >= 6, (i + 1) <= 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 7, 0, 0, 1, 0, 1, 0, 1));
    for (int j = 1; j < 8; j++)
      tbl.push_back(mk(0, 1, 0, 1, 0, j, 7 - j, 0, (7 - j) == 0, (7 - j) >= 6, (7 - j) <= 2, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 1, 1));

    do_reset(1'b1, 1'b1);
    for (int k = 0; k < tbl.size(); k++) step(tbl[k]);

    // Push and pop together at count 3: write wins, pop held and granted next cycle
    do_reset(1'b0, 1'b0);
    step(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    step(mk(1, 0, 1, 0, 1, 0, 2, 0, 0, 0, 1, 0, 0, 0));
    step(mk(1, 0, 1, 0, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 1, 1, 0, 3, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 1, 4, 0, 3, 0, 0, 0, 0, 0, 0, 1));

    // Threshold changes re-evaluate flags at the next edge; compares are inclusive
    umbral_af = 4'd3; umbral_ae = 4'd3;
    step(mk(0, 0, 0, 0, 4, 1, 3, 0, 0, 1, 1, 0, 0, 0));
    umbral_af = 4'd4; umbral_ae = 4'd2;
    step(mk(0, 0, 0, 0, 4, 1, 3, 0, 0, 0, 0, 0, 0, 0));
    umbral_af = 4'd6;

    // Interleaved traffic wrapping both pointers, then reset mid-stream
    do_reset(1'b0, 1'b0);
    wr = 0;
    rd = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        step(mk(1, 0, 1, 0, wr % 8, rd % 8, 1, 0, 0, 0, 1, 0, 0, 0));
        wr++;
      end else begin
        step(mk(0, 1, 0, 1, wr % 8, rd % 8, 0, 0, 1, 0, 1, 0, 0, 1));
        rd++;
      end
    end
    step(mk(1, 0, 1, 0, 4, 4, 1, 0, 0, 0, 1, 0, 0, 0));
    step(mk(1, 0, 1, 0, 5, 4, 2, 0, 0, 0, 1, 0, 0, 0));
    do_reset(1'b1, 1'b1);
    step(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    step(mk(0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
